wb_stage: RTL and testbench

WB_STAGE -- requirements
Module: wb_stage

---
 rtl/wb_stage_pkg.sv | 44 ++++
 rtl/wb_stage_if.sv | 31 +++
 rtl/constants.v | 13 +
 rtl/wb_pipe_reg.sv | 22 ++
 rtl/wb_stage.sv | 86 ++++++++
 tb/tb_wb_stage.sv | 162 ++++++++++++++++
 6 files changed

// File: rtl/wb_stage_pkg.sv
// Types shared by the writeback stage: word/register types, FSM states, MEM/WB payload.
// Latency: n/a (types and a pure helper function only).
// Backpressure: n/a.
`include "constants.v"

package wb_stage_pkg;

  typedef logic `WORD word_t;
  typedef logic [4:0] reg_idx_t;

  typedef enum logic [1:0] {
    RUN    = `WB_ST_RUN,
    LAST   = `WB_ST_LAST,
    HALTED = `WB_ST_HALTED
  } wb_state_t;

  // Contents of the MEM/WB register. The writeback value is already selected
  // and the write-enable already qualified, so the register output drives the
  // register-file port directly.
  typedef struct packed {
    logic     wr;
    reg_idx_t dest;
    word_t    data;
  } wb_pipe_t;

  // Build the MEM/WB payload from the raw MEM-stage signals. A terminator
  // never writes, and $0 is never a real write target.
  function automatic wb_pipe_t make_pipe(
    input logic     valid,
    input logic     wb_en,
    input logic     is_load,
    input logic     terminate,
    input reg_idx_t dest,
    input word_t    alu_result,
    input word_t    load_data
  );
    wb_pipe_t p;
    p.wr   = valid & wb_en & (dest != 5'd0) & ~terminate;
    p.dest = dest;
    p.data = is_load ? load_data : alu_result;
    return p;
  endfunction

endpackage

// File: rtl/wb_stage_if.sv
// MEM->WB bus: MEM-stage instruction fields in, register-file write port and halted out.
// Ports: mem_valid/mem_wb_en/mem_r/mem_dest/alu_result/load_data/mem_terminate (to stage),
//        wb_en/wb_dest/wb_data/halted (from stage). No backpressure: the stage always accepts.
interface wb_stage_if;
  import wb_stage_pkg::*;

  logic     mem_valid;
  logic     mem_wb_en;
  logic     mem_r;
  reg_idx_t mem_dest;
  word_t    alu_result;
  word_t    load_data;
  logic     mem_terminate;

  logic     wb_en;
  reg_idx_t wb_dest;
  word_t    wb_data;
  logic     halted;

  // master: the MEM stage side; slave: the writeback stage.
  modport master (
    output mem_valid, mem_wb_en, mem_r, mem_dest, alu_result, load_data, mem_terminate,
    input  wb_en, wb_dest, wb_data, halted
  );

  modport slave (
    input  mem_valid, mem_wb_en, mem_r, mem_dest, alu_result, load_data, mem_terminate,
    output wb_en, wb_dest, wb_data, halted
  );

endinterface

// File: rtl/constants.v
// Shared constants for the writeback stage: datapath word and FSM encodings.
// Included by wb_stage_pkg; guarded so repeated inclusion is harmless.
// Latency/backpressure: n/a (definitions only).
`ifndef WB_CONSTANTS_V
`define WB_CONSTANTS_V

`define WORD [31:0]

`define WB_ST_RUN    2'd0
`define WB_ST_LAST   2'd1
`define WB_ST_HALTED 2'd2

`endif

// File: rtl/wb_pipe_reg.sv
// MEM/WB pipeline register with synchronous active-low reset and capture enable.
// Ports: clk, rst, capture (load enable), d (next payload), q (registered payload).
// Latency: 1 cycle from d to q. Backpressure: none; capture=0 simply holds q.
module wb_pipe_reg
  import wb_stage_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     capture,
  input  wb_pipe_t d,
  output wb_pipe_t q
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      q <= '0;
    end else if (capture) begin
      q <= d;
    end
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: registers MEM results, drives the register-file write port,
// and runs the RUN/LAST/HALTED termination FSM. Optional retired counter under WB_PERF_CNT_EN.
// Ports: clk, rst (sync active-low), bus (wb_stage_if.slave), retired (WB_PERF_CNT_EN only).
// Latency: 1 cycle capture-to-output. Backpressure: none; inputs ignored outside RUN.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  wb_stage_if.slave        bus
`ifdef WB_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] retired
`endif
);

  wb_state_t state;
  wb_state_t state_nx;
  logic      capture;
  wb_pipe_t  pipe_d;
  wb_pipe_t  pipe_q;

  // A bubble's terminate bit is meaningless, so only a valid slot can end the program.
  logic      term_seen;
  assign term_seen = bus.mem_valid & bus.mem_terminate;

  assign pipe_d = make_pipe(bus.mem_valid, bus.mem_wb_en, bus.mem_r, bus.mem_terminate,
                            bus.mem_dest, bus.alu_result, bus.load_data);

  wb_pipe_reg u_pipe_reg (
    .clk     (clk),
    .rst     (rst),
    .capture (capture),
    .d       (pipe_d),
    .q       (pipe_q)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= RUN;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    capture  = 1'b0;
    case (state)
      RUN: begin
        capture = 1'b1;
        if (term_seen) begin
          state_nx = LAST;
        end
      end
      LAST:    state_nx = HALTED;
      HALTED:  state_nx = HALTED;
      default: state_nx = RUN;
    endcase
  end

  // Once LAST is entered the register is frozen on the terminator capture,
  // whose wr bit is already 0; the state term is a second guard.
  assign bus.wb_en   = pipe_q.wr & (state == RUN);
  assign bus.wb_dest = pipe_q.dest;
  assign bus.wb_data = pipe_q.data;
  assign bus.halted  = (state == HALTED);

`ifdef WB_PERF_CNT_EN
  // Counts every valid instruction accepted in RUN, writers or not.
  always_ff @(posedge clk) begin
    if (!rst) begin
      retired <= '0;
    end else if ((state == RUN) && bus.mem_valid) begin
      retired <= retired + CNT_W'(1);
    end
  end
`else
  // CNT_W only sizes the optional counter; keep it referenced in this build.
  if (CNT_W < 1) begin : g_cnt_w_unused
  end
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage.
// Drives the MEM->WB interface after each posedge and samples outputs 1 time unit later.
module tb_wb_stage;
  import wb_stage_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total  = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  wb_stage_if bus ();

`ifdef WB_PERF_CNT_EN
  logic [31:0] retired;
  wb_stage #(.CNT_W(32)) dut (.clk(clk), .rst(rst), .bus(bus), .retired(retired));
`else
  wb_stage #(.CNT_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
  endtask

  task automatic drive(input logic valid, input logic wen, input logic r, input logic term,
                       input logic [4:0] dest, input logic [31:0] alu, input logic [31:0] ld);
    bus.mem_valid     = valid;
    bus.mem_wb_en     = wen;
    bus.mem_r         = r;
    bus.mem_terminate = term;
    bus.mem_dest      = dest;
    bus.alu_result    = alu;
    bus.load_data     = ld;
  endtask

  task automatic chk_retired(input string tag, input logic [31:0] exp);
`ifdef WB_PERF_CNT_EN
    chk(tag, 64'(retired), 64'(exp));
`endif
  endtask

  initial begin
    // Reset with a write presented: reset must win over the capture.
    rst = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 5'd4, 32'h1111_1111, 32'h0);
    tick();
    tick();
    chk("rst_wb_en",   64'(bus.wb_en),   64'd0);
    chk("rst_wb_dest", 64'(bus.wb_dest), 64'd0);
    chk("rst_wb_data", 64'(bus.wb_data), 64'd0);
    chk("rst_halted",  64'(bus.halted),  64'd0);
    chk("rst_state",   64'(dut.state),   64'(RUN));
    chk_retired("rst_retired", 32'd0);

    // ALU write to $8.
    rst = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 5'd8, 32'h0000_002A, 32'h0000_0055);
    tick();
    chk("alu_wb_en",   64'(bus.wb_en),   64'd1);
    chk("alu_wb_dest", 64'(bus.wb_dest), 64'd8);
    chk("alu_wb_data", 64'(bus.wb_data), 64'h2A);
    chk_retired("alu_retired", 32'd1);

    // Load selects load_data over alu_result.
    drive(1'b1, 1'b1, 1'b1, 1'b0, 5'd3, 32'h0000_1000, 32'hDEAD_BEEF);
    tick();
    chk("load_wb_en",   64'(bus.wb_en),   64'd1);
    chk("load_wb_dest", 64'(bus.wb_dest), 64'd3);
    chk("load_wb_data", 64'(bus.wb_data), 64'hDEAD_BEEF);
    chk_retired("load_retired", 32'd2);

    // Write to $0 is suppressed but still retires.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0000_0077, 32'h0);
    tick();
    chk("r0_wb_en",   64'(bus.wb_en),   64'd0);
    chk("r0_wb_data", 64'(bus.wb_data), 64'h77);
    chk_retired("r0_retired", 32'd3);

    // Valid non-writing instruction.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd9, 32'h0000_1234, 32'h0);
    tick();
    chk("nowr_wb_en",   64'(bus.wb_en),   64'd0);
    chk("nowr_wb_dest", 64'(bus.wb_dest), 64'd9);
    chk_retired("nowr_retired", 32'd4);

    // Bubble carrying terminate=1 must not end the program.
    drive(1'b0, 1'b1, 1'b0, 1'b1, 5'd5, 32'h0000_0ABC, 32'h0);
    tick();
    chk("bub_wb_en",  64'(bus.wb_en),  64'd0);
    chk("bub_state",  64'(dut.state),  64'(RUN));
    chk("bub_halted", 64'(bus.halted), 64'd0);
    chk_retired("bub_retired", 32'd4);

    // Terminator with wb_en=1 captured at cycle N.
    drive(1'b1, 1'b1, 1'b0, 1'b1, 5'd7, 32'h0000_0099, 32'h0);
    tick();
    chk("term_state",  64'(dut.state),  64'(LAST));
    chk("term_wb_en",  64'(bus.wb_en),  64'd0);
    chk("term_halted", 64'(bus.halted), 64'd0);
    chk("term_dest",   64'(bus.wb_dest), 64'd7);
    chk_retired("term_retired", 32'd5);

    // Write presented at N+1 is ignored.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 5'd10, 32'h0000_0555, 32'h0);
    tick();
    chk("n2_state",   64'(dut.state),   64'(HALTED));
    chk("n2_halted",  64'(bus.halted),  64'd1);
    chk("n2_wb_en",   64'(bus.wb_en),   64'd0);
    chk("n2_wb_dest", 64'(bus.wb_dest), 64'd7);
    chk_retired("n2_retired", 32'd5);
    tick();
    chk("n3_halted", 64'(bus.halted), 64'd1);
    chk("n3_wb_en",  64'(bus.wb_en),  64'd0);
    chk_retired("n3_retired", 32'd5);

    // Reset while HALTED with a write still presented.
    rst = 1'b0;
    tick();
    chk("hrst_halted",  64'(bus.halted),  64'd0);
    chk("hrst_state",   64'(dut.state),   64'(RUN));
    chk("hrst_wb_en",   64'(bus.wb_en),   64'd0);
    chk("hrst_wb_data", 64'(bus.wb_data), 64'd0);
    chk_retired("hrst_retired", 32'd0);

    // Back in RUN: top register works.
    rst = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 5'd31, 32'hFFFF_FFFF, 32'h0);
    tick();
    chk("run2_wb_en",   64'(bus.wb_en),   64'd1);
    chk("run2_wb_dest", 64'(bus.wb_dest), 64'd31);
    chk("run2_wb_data", 64'(bus.wb_data), 64'hFFFF_FFFF);
    chk_retired("run2_retired", 32'd1);

    // Reset taken while in LAST leaves no residual write.
    drive(1'b1, 1'b0, 1'b0, 1'b1, 5'd2, 32'h0000_0003, 32'h0);
    tick();
    chk("last2_state", 64'(dut.state), 64'(LAST));
    rst = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 5'd6, 32'h0000_0066, 32'h0);
    tick();
    chk("lrst_state",   64'(dut.state),   64'(RUN));
    chk("lrst_wb_en",   64'(bus.wb_en),   64'd0);
    chk("lrst_wb_dest", 64'(bus.wb_dest), 64'd0);
    rst = 1'b1;
    tick();
    chk("post_wb_en",   64'(bus.wb_en),   64'd1);
    chk("post_wb_dest", 64'(bus.wb_dest), 64'd6);
    chk("post_wb_data", 64'(bus.wb_data), 64'h66);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
